// File: rtl/vram_pkg.sv
// Shared parameters, state/owner enums and the scroll address helper for the VRAM arbiter.
package vram_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 1536;
    localparam int COLS      = 64;
    localparam int ROWS      = NUM_WORDS / COLS;
    localparam int SCROLL_W  = 5;

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_ACK
    } cpu_state_t;

    typedef enum logic {
        OWN_DISP,
        OWN_CPU
    } rd_owner_t;

    // Rotates a text address down by whole rows; one subtract suffices because
    // a valid base plus at most ROWS-1 rows stays below 2*NUM_WORDS.
    function automatic logic [ADDR_W-1:0] wrap_addr(
        input logic [ADDR_W-1:0]   base,
        input logic [SCROLL_W-1:0] row
    );
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + ((ADDR_W+1)'(row) * (ADDR_W+1)'(COLS));
        if (sum >= (ADDR_W+1)'(NUM_WORDS)) begin
            sum = sum - (ADDR_W+1)'(NUM_WORDS);
        end
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/vram_rd_tag.sv
// Two-stage valid/owner pipeline that follows each RAM read so its data can be
// steered to the display or the CPU when it comes back.
module vram_rd_tag
    import vram_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid,
    input  rd_owner_t issue_owner,
    output logic      q_valid,
    output rd_owner_t q_owner,
    output logic      out_valid,
    output rd_owner_t out_owner
);

    logic      valid_reg [2];
    rd_owner_t owner_reg [2];

    // Stage 0 marks the cycle mem_q is valid; stage 1 marks the cycle the
    // registered copy is presented downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg[0] <= 1'b0;
            valid_reg[1] <= 1'b0;
            owner_reg[0] <= OWN_DISP;
            owner_reg[1] <= OWN_DISP;
        end else begin
            valid_reg[0] <= issue_valid;
            owner_reg[0] <= issue_owner;
            valid_reg[1] <= valid_reg[0];
            owner_reg[1] <= owner_reg[0];
        end
    end

    assign q_valid   = valid_reg[0];
    assign q_owner   = owner_reg[0];
    assign out_valid = valid_reg[1];
    assign out_owner = owner_reg[1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text RAM arbiter: display fetches always win the slot, the CPU
// uses free slots via req/ack. Define VRAM_SCROLL_EN for the row-scroll register.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    logic              disp_pend_reg;
    logic [ADDR_W-1:0] disp_addr_reg;
    logic [ADDR_W-1:0] disp_issue_addr;
    logic [DATA_W-1:0] disp_data_reg;
    cpu_state_t        c_state_reg, c_state_next;
    logic              cpu_err_reg, cpu_err_next;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic              scroll_hit;
    logic              scroll_wr;
    logic              scroll_rd;

    logic              tag_q_valid, tag_out_valid;
    rd_owner_t         tag_q_owner, tag_out_owner;
    rd_owner_t         issue_owner;

`ifdef VRAM_SCROLL_EN
    logic [SCROLL_W-1:0] scroll_row_reg;

    assign scroll_hit      = (cpu_addr == ADDR_W'(NUM_WORDS));
    assign disp_issue_addr = wrap_addr(disp_addr_reg, scroll_row_reg);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            scroll_row_reg <= '0;
        end else if (scroll_wr) begin
            scroll_row_reg <= cpu_wdata[SCROLL_W-1:0];
        end
    end
`else
    assign scroll_hit      = 1'b0;
    assign disp_issue_addr = disp_addr_reg;
`endif

    // A pending fetch always issues the cycle after it is latched, so a new
    // strobe in that same cycle simply reloads the slot.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            disp_pend_reg <= 1'b0;
            disp_addr_reg <= '0;
        end else begin
            disp_pend_reg <= disp_req;
            if (disp_req) begin
                disp_addr_reg <= disp_addr;
            end
        end
    end

    always_comb begin
        c_state_next = c_state_reg;
        cpu_err_next = cpu_err_reg;
        mem_addr     = '0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        mem_wdata    = '0;
        scroll_wr    = 1'b0;
        scroll_rd    = 1'b0;
        issue_owner  = OWN_DISP;

        case (c_state_reg)
            C_WAIT:  c_state_next = C_ACK;
            C_ACK:   c_state_next = C_IDLE;
            default: c_state_next = C_IDLE;
        endcase

        if (disp_pend_reg) begin
            mem_addr = disp_issue_addr;
            mem_rden = 1'b1;
        end else if (c_state_reg == C_IDLE && cpu_req && !RESET) begin
            // The held request keeps the bus combinational, so reset must mask it.
            cpu_err_next = 1'b0;
            c_state_next = C_ACK;
            if (scroll_hit) begin
                if (!cpu_we) begin
                    scroll_rd = 1'b1;
                end else if (cpu_wdata < DATA_W'(ROWS)) begin
                    scroll_wr = 1'b1;
                end else begin
                    cpu_err_next = 1'b1;
                end
            end else if (cpu_addr >= ADDR_W'(NUM_WORDS)) begin
                cpu_err_next = 1'b1;
            end else if (cpu_we) begin
                mem_addr  = cpu_addr;
                mem_wren  = 1'b1;
                mem_wdata = cpu_wdata;
            end else begin
                mem_addr     = cpu_addr;
                mem_rden     = 1'b1;
                issue_owner  = OWN_CPU;
                c_state_next = C_WAIT;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            c_state_reg <= C_IDLE;
            cpu_err_reg <= 1'b0;
        end else begin
            c_state_reg <= c_state_next;
            cpu_err_reg <= cpu_err_next;
        end
    end

    vram_rd_tag u_rd_tag (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .issue_valid (mem_rden),
        .issue_owner (issue_owner),
        .q_valid     (tag_q_valid),
        .q_owner     (tag_q_owner),
        .out_valid   (tag_out_valid),
        .out_owner   (tag_out_owner)
    );

    // Read data is steered purely by the tag, never by the CPU state.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            disp_data_reg <= '0;
            cpu_rdata_reg <= '0;
        end else begin
            if (tag_q_valid && tag_q_owner == OWN_DISP) begin
                disp_data_reg <= mem_q;
            end
            if (tag_q_valid && tag_q_owner == OWN_CPU) begin
                cpu_rdata_reg <= mem_q;
            end
`ifdef VRAM_SCROLL_EN
            if (scroll_rd) begin
                cpu_rdata_reg <= DATA_W'(scroll_row_reg);
            end
`endif
        end
    end

    assign disp_data  = disp_data_reg;
    assign disp_valid = tag_out_valid && (tag_out_owner == OWN_DISP);
    assign cpu_rdata  = cpu_rdata_reg;
    assign cpu_ack    = (c_state_reg == C_ACK);
    assign cpu_err    = (c_state_reg == C_ACK) && cpu_err_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 1536 x 8 RAM model.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic              CLOCK_50 = 1'b0;
    logic              RESET    = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              cpu_req = 1'b0;
    logic              cpu_we  = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wren_cnt = 0;
    int n;

    logic [DATA_W-1:0] ram  [NUM_WORDS];
    logic [DATA_W-1:0] gold [NUM_WORDS];
    logic [ADDR_W-1:0] q_addr = '0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } disp_exp_t;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              chk_data;
        int                due;
    } cpu_exp_t;

    disp_exp_t disp_q[$];
    cpu_exp_t  cpu_q[$];
    disp_exp_t de;
    cpu_exp_t  ce;

    vram_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .mem_addr   (mem_addr),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_wdata  (mem_wdata),
        .mem_q      (mem_q)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        cyc = cyc + 1;
        if (mem_wren) begin
            wren_cnt = wren_cnt + 1;
            if (int'(mem_addr) < NUM_WORDS) ram[mem_addr] <= mem_wdata;
        end
        if (mem_rden) q_addr <= mem_addr;
    end

    assign mem_q = (int'(q_addr) < NUM_WORDS) ? ram[q_addr] : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cpu_start(input logic we, input int addr, input logic [DATA_W-1:0] wdata,
                             input int lat, input logic exp_err, input logic [DATA_W-1:0] exp_rdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = ADDR_W'(addr);
        cpu_wdata = wdata;
        cpu_q.push_back('{exp_rdata, exp_err, !we, cyc + lat});
        if (we && !exp_err && addr < NUM_WORDS) gold[addr] = wdata;
    endtask

    task automatic cpu_finish();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (cpu_ack) seen = 1'b1;
        end
        if (!seen) check_eq("cpu_ack_timeout", 32'd0, 32'd1);
        step();
        cpu_req = 1'b0;
    endtask

    task automatic disp_fetch(input int addr, input int eff);
        disp_req  = 1'b1;
        disp_addr = ADDR_W'(addr);
        disp_q.push_back('{gold[eff], cyc + 3});
        step();
        disp_req = 1'b0;
        @(negedge CLOCK_50);
        check_eq("disp_issue_rden", 32'(mem_rden), 32'd1);
        check_eq("disp_issue_addr", 32'(mem_addr), 32'(eff));
        step();
    endtask

    // Scoreboard: pops the expected entry whenever the DUT pulses a result.
    always @(negedge CLOCK_50) begin
        if (!RESET) begin
            if (disp_q.size() > 0 && cyc > disp_q[0].due) begin
                de = disp_q.pop_front();
                check_eq("disp_missing", 32'd0, 32'd1);
            end
            if (cpu_q.size() > 0 && cyc > cpu_q[0].due) begin
                ce = cpu_q.pop_front();
                check_eq("cpu_ack_missing", 32'd0, 32'd1);
            end
            if (disp_valid) begin
                if (disp_q.size() == 0) begin
                    check_eq("disp_spurious", 32'd1, 32'd0);
                end else begin
                    de = disp_q.pop_front();
                    $display("txn disp data=%02h expected=%02h cycle=%0d", disp_data, de.data, cyc);
                    check_eq("disp_data", 32'(disp_data), 32'(de.data));
                    check_eq("disp_cycle", 32'(cyc), 32'(de.due));
                end
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check_eq("cpu_ack_spurious", 32'd1, 32'd0);
                end else begin
                    ce = cpu_q.pop_front();
                    $display("txn cpu ack err=%0d rdata=%02h cycle=%0d", cpu_err, cpu_rdata, cyc);
                    check_eq("cpu_err", 32'(cpu_err), 32'(ce.err));
                    if (ce.chk_data) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(ce.rdata));
                    check_eq("cpu_ack_cycle", 32'(cyc), 32'(ce.due));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            ram[i]  = 8'(i);
            gold[i] = 8'(i);
        end

        // Reset state
        @(negedge CLOCK_50);
        check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
        check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check_eq("rst_cpu_err", 32'(cpu_err), 32'd0);
        check_eq("rst_mem_en", 32'({mem_rden, mem_wren}), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_data", 32'({disp_data, cpu_rdata}), 32'd0);
        step();
        RESET = 1'b0;
        repeat (2) step();

        // Display alone: addr 65 -> 0x41, read issued in cycle 1
        disp_req  = 1'b1;
        disp_addr = 11'd65;
        disp_q.push_back('{8'h41, cyc + 3});
        @(negedge CLOCK_50);
        check_eq("disp0_rden_cycle0", 32'(mem_rden), 32'd0);
        step();
        disp_req = 1'b0;
        @(negedge CLOCK_50);
        check_eq("disp0_rden_cycle1", 32'(mem_rden), 32'd1);
        check_eq("disp0_addr_cycle1", 32'(mem_addr), 32'd65);
        repeat (5) step();

        // CPU write 0x5A to 100, then read it back
        cpu_start(1'b1, 100, 8'h5A, 1, 1'b0, 8'h00);
        @(negedge CLOCK_50);
        check_eq("wr_issue", 32'({mem_wren, mem_rden}), 32'b10);
        check_eq("wr_addr", 32'(mem_addr), 32'd100);
        check_eq("wr_data", 32'(mem_wdata), 32'h5A);
        cpu_finish();
        cpu_start(1'b0, 100, 8'h00, 2, 1'b0, 8'h5A);
        cpu_finish();

        // Address boundaries 0 and NUM_WORDS-1
        cpu_start(1'b1, 0, 8'hA5, 1, 1'b0, 8'h00);
        cpu_finish();
        cpu_start(1'b0, 0, 8'h00, 2, 1'b0, 8'hA5);
        cpu_finish();
        cpu_start(1'b0, NUM_WORDS - 1, 8'h00, 2, 1'b0, gold[NUM_WORDS - 1]);
        cpu_finish();
        repeat (2) step();

        // Same-cycle strobe: CPU takes the free slot, display issues next cycle
        n = cyc;
        disp_req  = 1'b1;
        disp_addr = 11'd66;
        disp_q.push_back('{gold[66], n + 3});
        cpu_start(1'b0, 200, 8'h00, 2, 1'b0, gold[200]);
        @(negedge CLOCK_50);
        check_eq("colA_cpu_issue_addr", 32'(mem_addr), 32'd200);
        step();
        disp_req = 1'b0;
        @(negedge CLOCK_50);
        check_eq("colA_disp_issue_addr", 32'(mem_addr), 32'd66);
        check_eq("colA_disp_issue_rden", 32'(mem_rden), 32'd1);
        cpu_finish();
        repeat (3) step();

        // Collision: CPU request lands while the pending fetch owns the slot
        disp_req  = 1'b1;
        disp_addr = 11'd77;
        disp_q.push_back('{gold[77], cyc + 3});
        step();
        disp_req = 1'b0;
        cpu_start(1'b0, 300, 8'h00, 3, 1'b0, gold[300]);
        @(negedge CLOCK_50);
        check_eq("colB_disp_addr", 32'(mem_addr), 32'd77);
        step();
        @(negedge CLOCK_50);
        check_eq("colB_cpu_addr", 32'(mem_addr), 32'd300);
        check_eq("colB_cpu_rden", 32'(mem_rden), 32'd1);
        cpu_finish();
        repeat (3) step();

        // Out-of-range accesses are rejected without touching the RAM
        n = wren_cnt;
        cpu_start(1'b1, 1600, 8'h33, 1, 1'b1, 8'h00);
        cpu_finish();
        check_eq("oor_no_wren", 32'(wren_cnt), 32'(n));
`ifndef VRAM_SCROLL_EN
        cpu_start(1'b1, NUM_WORDS, 8'h01, 1, 1'b1, 8'h00);
        cpu_finish();
        check_eq("oor1536_no_wren", 32'(wren_cnt), 32'(n));
        disp_fetch(1500, 1500);
`endif
        repeat (3) step();

        // Reset while the CPU read waits for its data
        cpu_start(1'b0, 400, 8'h00, 2, 1'b0, gold[400]);
        step();
        RESET = 1'b1;
        #2;
        check_eq("midrst_mem", 32'({mem_rden, mem_wren}), 32'd0);
        check_eq("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("midrst_ack", 32'({cpu_ack, cpu_err, disp_valid}), 32'd0);
        check_eq("midrst_rdata", 32'(cpu_rdata), 32'd0);
        cpu_q.delete();
        step();
        cpu_req = 1'b0;
        RESET   = 1'b0;
        repeat (5) step();
        cpu_start(1'b0, 400, 8'h00, 2, 1'b0, gold[400]);
        cpu_finish();
        disp_fetch(12, 12);
        repeat (3) step();

`ifdef VRAM_SCROLL_EN
        // Scroll by two rows: 1500 + 128 wraps to 92
        cpu_start(1'b1, NUM_WORDS, 8'd2, 1, 1'b0, 8'h00);
        cpu_finish();
        disp_fetch(1500, 92);
        disp_fetch(10, 138);
        cpu_start(1'b1, NUM_WORDS, 8'd30, 1, 1'b1, 8'h00);
        cpu_finish();
        cpu_start(1'b0, NUM_WORDS, 8'h00, 1, 1'b0, 8'd2);
        cpu_finish();
        disp_fetch(1500, 92);
        repeat (3) step();
`endif

        repeat (5) step();
        check_eq("disp_queue_empty", 32'(disp_q.size()), 32'd0);
        check_eq("cpu_queue_empty", 32'(cpu_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
